// File: rtl/free_list.sv
// free_list -- physical-register free list for rename.
//
// Circular FIFO of free physical tags. At reset it holds the tags that are
// not identity-mapped to architectural registers (NUM_AREG .. NUM_PREG-1).
// One tag may be popped per cycle by dispatch. Up to three tags may be
// returned per cycle: one from commit and two from rollback squashes.
//
// Ports:
//   clk                   rising-edge clock
//   rst                   asynchronous, active-low reset
//   alloc_req             dispatch wants one destination tag
//   alloc_ready           a tag is available and pop is not stalled
//   alloc_P_rd            tag at the list head (valid when alloc_ready)
//   stall                 ROB recovery; blocks pop only
//   commit_wb_en          commit releases commit_P_rd_old
//   commit_P_rd_old       tag freed on commit
//   rollback_en_0/1       ROB squashing entry 0/1
//   rollback_P_rd_new_0/1 speculative tags returned on squash
//   free_count            number of tags currently held
//   overflow_err          sticky: a returned tag was dropped on a full list
module free_list #(
   parameter int NUM_PREG = 128,
   parameter int NUM_AREG = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       alloc_req,
   output logic       alloc_ready,
   output logic [6:0] alloc_P_rd,
   input  logic       stall,
   input  logic       commit_wb_en,
   input  logic [6:0] commit_P_rd_old,
   input  logic       rollback_en_0,
   input  logic [6:0] rollback_P_rd_new_0,
   input  logic       rollback_en_1,
   input  logic [6:0] rollback_P_rd_new_1,
   output logic [6:0] free_count,
   output logic       overflow_err
);

   localparam int DEPTH = NUM_PREG - NUM_AREG;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;
   localparam int TW    = 7;

   logic [TW-1:0] fifo [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic          pop;
   logic [2:0]    cand_v;
   logic [TW-1:0] cand_t  [3];
   logic [TW-1:0] wr_tag  [3];
   logic [PW-1:0] wr_idx  [3];
   logic [1:0]    n_valid;
   logic [1:0]    n_acc;
   logic [CW:0]   space;
   logic          drop;

   assign alloc_ready = (count != '0) && !stall;
   assign alloc_P_rd  = fifo[head];
   assign free_count  = count;
   assign pop         = alloc_req && alloc_ready;

   always_comb begin
      cand_v[0] = commit_wb_en  && (commit_P_rd_old     != '0);
      cand_v[1] = rollback_en_0 && (rollback_P_rd_new_0 != '0);
      cand_v[2] = rollback_en_1 && (rollback_P_rd_new_1 != '0);
      cand_t[0] = commit_P_rd_old;
      cand_t[1] = rollback_P_rd_new_0;
      cand_t[2] = rollback_P_rd_new_1;
   end

   // Compact valid candidates in priority order into write slots 0..n_valid-1.
   always_comb begin
      n_valid = '0;
      for (int unsigned k = 0; k < 3; k++) begin
         wr_tag[k] = '0;
         wr_idx[k] = tail + PW'(k);
      end
      for (int unsigned i = 0; i < 3; i++) begin
         if (cand_v[i]) begin
            wr_tag[n_valid] = cand_t[i];
            n_valid         = n_valid + 2'd1;
         end
      end
   end

   // A same-cycle pop frees a slot, so it counts toward push capacity.
   // Excess is trimmed from the end of the compacted list, i.e. lowest
   // priority first.
   always_comb begin
      space = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
      if ({{(CW-1){1'b0}}, n_valid} > space) begin
         n_acc = space[1:0];
      end else begin
         n_acc = n_valid;
      end
      drop = (n_acc != n_valid);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo[i] <= TW'(NUM_AREG + i);
         end
         head         <= '0;
         tail         <= '0;
         count        <= CW'(DEPTH);
         overflow_err <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < 3; k++) begin
            if (k < 32'(n_acc)) begin
               fifo[wr_idx[k]] <= wr_tag[k];
            end
         end
         head  <= head + PW'(pop);
         tail  <= tail + PW'(n_acc);
         count <= count + CW'(n_acc) - CW'(pop);
         if (drop) begin
            overflow_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

   logic       clk;
   logic       rst;
   logic       alloc_req;
   logic       alloc_ready;
   logic [6:0] alloc_P_rd;
   logic       stall;
   logic       commit_wb_en;
   logic [6:0] commit_P_rd_old;
   logic       rollback_en_0;
   logic [6:0] rollback_P_rd_new_0;
   logic       rollback_en_1;
   logic [6:0] rollback_P_rd_new_1;
   logic [6:0] free_count;
   logic       overflow_err;

   free_list #(.NUM_PREG(128), .NUM_AREG(64)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .alloc_req           (alloc_req),
      .alloc_ready         (alloc_ready),
      .alloc_P_rd          (alloc_P_rd),
      .stall               (stall),
      .commit_wb_en        (commit_wb_en),
      .commit_P_rd_old     (commit_P_rd_old),
      .rollback_en_0       (rollback_en_0),
      .rollback_P_rd_new_0 (rollback_P_rd_new_0),
      .rollback_en_1       (rollback_en_1),
      .rollback_P_rd_new_1 (rollback_P_rd_new_1),
      .free_count          (free_count),
      .overflow_err        (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: the free list is a plain queue of tags, capacity 64.
   int mq[$];
   bit m_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < 64; i++) mq.push_back(64 + i);
      m_ovf = 1'b0;
   endtask

   task automatic drive_idle();
      alloc_req = 0; stall = 0;
      commit_wb_en = 0; commit_P_rd_old = '0;
      rollback_en_0 = 0; rollback_P_rd_new_0 = '0;
      rollback_en_1 = 0; rollback_P_rd_new_1 = '0;
   endtask

   // Reset asserted while inputs may still be active; state must not move.
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("rst_count_async", 32'(free_count), 64);
      chk("rst_head_async", 32'(alloc_P_rd), 64);
      chk("rst_ovf_async", 32'(overflow_err), 0);
      @(posedge clk); #1;
      chk("rst_count_held", 32'(free_count), 64);
      @(negedge clk);
      drive_idle();
      #1;
      chk("rst_ready", 32'(alloc_ready), 1);
      rst = 1'b1;
   endtask

   task automatic step(input bit req, input bit st,
                       input bit cwb, input int ct,
                       input bit r0, input int t0,
                       input bit r1, input int t1);
      bit exp_ready;
      int cands[$];
      @(negedge clk);
      alloc_req = req; stall = st;
      commit_wb_en = cwb; commit_P_rd_old = 7'(ct);
      rollback_en_0 = r0; rollback_P_rd_new_0 = 7'(t0);
      rollback_en_1 = r1; rollback_P_rd_new_1 = 7'(t1);
      #1;
      exp_ready = (mq.size() != 0) && !st;
      chk("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
      if (exp_ready) chk("alloc_P_rd", 32'(alloc_P_rd), 32'(mq[0]));
      if (req && exp_ready) void'(mq.pop_front());
      if (cwb && ct != 0) cands.push_back(ct);
      if (r0 && t0 != 0) cands.push_back(t0);
      if (r1 && t1 != 0) cands.push_back(t1);
      foreach (cands[i]) begin
         if (mq.size() < 64) mq.push_back(cands[i]);
         else m_ovf = 1'b1;
      end
      @(posedge clk); #1;
      chk("free_count", 32'(free_count), 32'(mq.size()));
      chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      do_reset();

      // Drain the whole list in order.
      for (int i = 0; i < 64; i++) begin
         chk("drain_order", 32'(alloc_P_rd), 32'(64 + i));
         step(1, 0, 0, 0, 0, 0, 0, 0);
      end
      chk("drained_count", 32'(free_count), 0);
      chk("drained_ready", 32'(alloc_ready), 0);

      // Push into empty list while requesting: not ready this cycle.
      step(1, 0, 1, 5, 0, 0, 0, 0);
      chk("empty_push_ready_next", 32'(alloc_ready), 1);
      chk("empty_push_tag_next", 32'(alloc_P_rd), 5);
      chk("empty_push_count", 32'(free_count), 1);

      // Build to 10 then pop + three pushes in one cycle.
      for (int i = 0; i < 9; i++) step(0, 0, 1, 10 + i, 0, 0, 0, 0);
      chk("count_ten", 32'(free_count), 10);
      step(1, 0, 1, 7, 1, 90, 1, 91);
      chk("triple_push_count", 32'(free_count), 12);

      // Zero tags never enter.
      step(0, 0, 1, 0, 1, 0, 1, 33);
      chk("zero_filter_count", 32'(free_count), 13);
      // Drain to see stored order 10..18, 7, 90, 91, 33.
      for (int i = 0; i < 13; i++) step(1, 0, 0, 0, 0, 0, 0, 0);

      // Full list drops a commit and sets sticky overflow.
      do_reset();
      step(0, 0, 1, 3, 0, 0, 0, 0);
      chk("full_drop_ovf", 32'(overflow_err), 1);
      chk("full_drop_count", 32'(free_count), 64);
      // Pop and two returns on a full list: one accepted, one dropped.
      step(1, 0, 0, 0, 1, 44, 1, 45);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("ovf_sticky", 32'(overflow_err), 1);
      do_reset();
      chk("ovf_cleared", 32'(overflow_err), 0);

      // Stall blocks pop but not pushes.
      for (int i = 0; i < 44; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("count_twenty", 32'(free_count), 20);
      step(1, 1, 0, 0, 1, 40, 1, 41);
      chk("stall_count", 32'(free_count), 22);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("post_stall_count", 32'(free_count), 21);

      // Random traffic: push-heavy then pop-heavy phases, wrapping pointers.
      for (int ph = 0; ph < 4; ph++) begin
         for (int n = 0; n < 150; n++) begin
            bit req, st;
            req = (ph % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 5) == 0);
            step(req, st,
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
                 bit'($urandom_range(0, 2) == 0), int'($urandom_range(0, 127)),
                 bit'($urandom_range(0, 2) == 0), int'($urandom_range(0, 127)));
         end
      end

      // Mid-operation reset with inputs active.
      @(negedge clk);
      alloc_req = 1; commit_wb_en = 1; commit_P_rd_old = 7'd9;
      do_reset();
      step(1, 0, 0, 0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
